// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder slice.
// Holds the FSM encoding, bus widths and the default data-window base.
package risc_mem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] DATA_BASE_DEFAULT = 16'h1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous word RAM: write and registered read take effect on the clock edge.
// No reset; contents survive a system reset.
module mem_array #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes a window at BASE_ADDR and answers with a mem_ready pulse
// WAIT_CYCLES+1 cycles after a request is seen in IDLE; the initiator holds the request until then.
module data_mem_responder
  import risc_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DATA_BASE_DEFAULT,
  parameter int unsigned       DEPTH_LOG2  = 8,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              addr_error
);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [DATA_W-1:0]     lat_wdata;
  logic                  lat_read;
  logic                  lat_we;
  logic                  lat_err;
  logic [DATA_W-1:0]     read_data_q;

  logic [ADDR_W-1:0]     offset;
  logic                  in_range;
  logic                  live_req;
  logic                  live_err;
  logic                  to_respond;
  logic                  ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_q;

  // Unsigned wrap below BASE_ADDR is caught by the explicit >= test.
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && ((offset >> DEPTH_LOG2) == '0);
  assign live_req = mem_read | mem_write;
  assign live_err = (mem_read & mem_write) | ~in_range;

  assign to_respond = ((state == IDLE) && live_req && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  // The RAM read is launched on the edge entering RESPOND, so with zero wait
  // states it must use the live address rather than the latched one.
  assign ram_addr = (state == IDLE) ? offset[DEPTH_LOG2-1:0] : lat_idx;
  assign ram_re   = to_respond && reset;
  assign ram_we   = (state == RESPOND) && lat_we && reset;

  assign read_data = ((state == RESPOND) && lat_read)
                   ? (lat_err ? '0 : ram_q)
                   : read_data_q;

  mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (lat_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      mem_ready   <= 1'b0;
      addr_error  <= 1'b0;
      read_data_q <= '0;
    end else begin
      mem_ready  <= to_respond;
      addr_error <= to_respond && ((state == IDLE) ? live_err : lat_err);
      case (state)
        IDLE: begin
          if (live_req) begin
            lat_idx   <= offset[DEPTH_LOG2-1:0];
            lat_wdata <= write_data;
            lat_read  <= mem_read & ~mem_write;
            lat_we    <= mem_write & ~mem_read & in_range;
            lat_err   <= live_err;
            cnt       <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? RESPOND : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESPOND;
          else             cnt   <= cnt - 4'd1;
        end
        RESPOND: begin
          state <= IDLE;
          if (lat_read) read_data_q <= lat_err ? '0 : ram_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one with none.
// Expected responses are queued on issue and popped when mem_ready is seen.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [15:0] address    [2];
  logic [15:0] write_data [2];
  logic [15:0] read_data  [2];
  logic        mem_ready  [2];
  logic        addr_error [2];

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(16'h1000), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(reset), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .mem_ready(mem_ready[0]), .addr_error(addr_error[0]));

  data_mem_responder #(.BASE_ADDR(16'h1000), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .mem_ready(mem_ready[1]), .addr_error(addr_error[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model [2][256];
  bit          known [2][256];
  logic [15:0] last_rd [2];
  bit          last_known [2];

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Model the request, queue its expected response and drive it onto the DUT.
  task automatic issue(input int d, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] wd);
    logic        err;
    logic [15:0] rd;
    bit          k;
    int          idx;
    err = (r && w) || (a < 16'h1000) || (a > 16'h10FF);
    idx = int'(a[7:0]);
    if (r && !w) begin
      rd = err ? 16'h0000 : model[d][idx];
      k  = err ? 1'b1 : known[d][idx];
      last_rd[d]    = rd;
      last_known[d] = k;
    end else begin
      rd = last_rd[d];
      k  = last_known[d];
      if (w && !r && !err) begin
        model[d][idx] = wd;
        known[d][idx] = 1'b1;
      end
    end
    sb.push_back('{cyc + 1 + wc(d), err, rd, k});
    mem_read[d]   = r;
    mem_write[d]  = w;
    address[d]    = a;
    write_data[d] = wd;
  endtask

  task automatic wait_rsp(input int d);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_ready[d] === 1'b1) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready dut%0d cyc=%0d", d, cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc !== e.cyc) begin
            failures++;
            $display("FAIL latency dut%0d got_cyc=%0d exp_cyc=%0d", d, cyc, e.cyc);
          end
          checks++;
          if (addr_error[d] !== e.err) begin
            failures++;
            $display("FAIL addr_error dut%0d got=%b exp=%b", d, addr_error[d], e.err);
          end
          if (e.chk) begin
            checks++;
            if (read_data[d] !== e.rdata) begin
              failures++;
              $display("FAIL read_data dut%0d got=%h exp=%h", d, read_data[d], e.rdata);
            end
          end
        end
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
      end else begin
        checks++;
        if (addr_error[d] !== 1'b0) begin
          failures++;
          $display("FAIL err_without_ready dut%0d got=%b exp=0", d, addr_error[d]);
        end
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ready_timeout dut%0d cyc=%0d", d, cyc);
      sb.delete();
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
    end
  endtask

  task automatic transact(input int d, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] wd);
    @(negedge clk);
    issue(d, r, w, a, wd);
    wait_rsp(d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      address[d] = 16'h1000; write_data[d] = 16'h0000;
      last_rd[d] = 16'h0000; last_known[d] = 1'b1;
    end
    mem_read[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (mem_ready[d] !== 1'b0 || addr_error[d] !== 1'b0 || read_data[d] !== 16'h0000) begin
          failures++;
          $display("FAIL reset_outputs dut%0d got rdy=%b err=%b rd=%h exp 0/0/0000",
                   d, mem_ready[d], addr_error[d], read_data[d]);
        end
      end
    end
    reset = 1'b1;
    sb.push_back('{cyc + 1 + 2, 1'b0, 16'h0000, 1'b0});
    last_known[0] = 1'b0;
    wait_rsp(0);
  endtask

  task automatic test_write_read();
    transact(0, 1'b0, 1'b1, 16'h1004, 16'hBEEF);
    transact(0, 1'b1, 1'b0, 16'h1004, 16'h0000);
    transact(0, 1'b0, 1'b1, 16'h1006, 16'h1111);
    transact(0, 1'b1, 1'b0, 16'h1006, 16'h0000);
  endtask

  task automatic test_boundaries();
    transact(0, 1'b0, 1'b1, 16'h10FF, 16'hA5A5);
    transact(0, 1'b1, 1'b0, 16'h10FF, 16'h0000);
    transact(0, 1'b0, 1'b1, 16'h1000, 16'h1357);
    transact(0, 1'b0, 1'b1, 16'h1100, 16'hFFFF);
    transact(0, 1'b1, 1'b0, 16'h1000, 16'h0000);
    transact(0, 1'b1, 1'b0, 16'h1100, 16'h0000);
    transact(0, 1'b0, 1'b1, 16'h1001, 16'h2222);
    transact(0, 1'b1, 1'b0, 16'h0FFF, 16'h0000);
    transact(0, 1'b1, 1'b0, 16'h10FF, 16'h0000);
  endtask

  task automatic test_illegal();
    transact(0, 1'b0, 1'b1, 16'h1002, 16'h1234);
    transact(0, 1'b1, 1'b0, 16'h1000, 16'h0000);
    transact(0, 1'b1, 1'b1, 16'h1002, 16'h5555);
    transact(0, 1'b1, 1'b0, 16'h1002, 16'h0000);
  endtask

  task automatic test_reset_mid_wait();
    transact(0, 1'b0, 1'b1, 16'h1008, 16'h0011);
    @(negedge clk);
    mem_write[0] = 1'b1; address[0] = 16'h1008; write_data[0] = 16'hAAAA;
    @(negedge clk);
    reset = 1'b0;
    mem_write[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 16'h0000; last_known[d] = 1'b1;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (mem_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL abandoned_ready cyc=%0d got=%b exp=0", cyc, mem_ready[0]);
      end
    end
    transact(0, 1'b1, 1'b0, 16'h1008, 16'h0000);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   k;
    logic prev;
    transact(1, 1'b0, 1'b1, 16'h1010, 16'h0A0A);
    transact(1, 1'b0, 1'b1, 16'h1011, 16'h0B0B);
    transact(1, 1'b1, 1'b0, 16'h10FF, 16'h0000);
    @(negedge clk);
    k = cyc;
    mem_read[1] = 1'b1; address[1] = 16'h1010;
    sb.push_back('{k + 1, 1'b0, 16'h0A0A, 1'b1});
    sb.push_back('{k + 3, 1'b0, 16'h0B0B, 1'b1});
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready[1] === 1'b1) begin
        checks++;
        if (prev) begin
          failures++;
          $display("FAIL consecutive_ready cyc=%0d got=1 exp=0", cyc);
        end
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b2b_extra_ready cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc !== e.cyc || read_data[1] !== e.rdata || addr_error[1] !== e.err) begin
            failures++;
            $display("FAIL b2b_response got cyc=%0d rd=%h err=%b exp cyc=%0d rd=%h err=%b",
                     cyc, read_data[1], addr_error[1], e.cyc, e.rdata, e.err);
          end
        end
      end
      if (cyc == k + 1) address[1] = 16'h1011;
      if (cyc == k + 3) mem_read[1] = 1'b0;
      prev = mem_ready[1];
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing got_pending=%0d exp=0", sb.size());
      sb.delete();
    end
    last_rd[1] = 16'h0B0B; last_known[1] = 1'b1;
    transact(1, 1'b1, 1'b0, 16'h1100, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_boundaries();
    test_illegal();
    test_reset_mid_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end
endmodule
